// File: rtl/frame_capture_ctrl_if.sv
// Bundle between the frame capture controller, the camera path,
// the classifier read port and the single-port frame RAM.
// The environment (camera + reader + RAM) is the master; the controller is the slave.
interface frame_capture_ctrl_if #(
   parameter int ADDR_W = 17
);
   logic              start_i;
   logic              release_i;
   logic              vsync_i;
   logic              pix_valid_i;
   logic              rd_req_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_we_o;
   logic              rd_valid_o;
   logic              frame_ready_o;
   logic              busy_o;
   logic              frame_err_o;

   modport master (
      output start_i, release_i, vsync_i, pix_valid_i, rd_req_i, rd_addr_i,
      input  mem_addr_o, mem_we_o, rd_valid_o, frame_ready_o, busy_o, frame_err_o
   );

   modport slave (
      input  start_i, release_i, vsync_i, pix_valid_i, rd_req_i, rd_addr_i,
      output mem_addr_o, mem_we_o, rd_valid_o, frame_ready_o, busy_o, frame_err_o
   );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Frame RAM sequencer: arms on start, captures one whole camera frame
// starting at a frame boundary, then holds it for random-access reads
// by the classifier until released.
module frame_capture_ctrl #(
   parameter int H_RES  = 320,
   parameter int V_RES  = 240,
   parameter int ADDR_W = 17
) (
   input  logic                 CLK25,
   input  logic                 RESET_N,
   frame_capture_ctrl_if.slave  bus
);

   localparam int                FRAME     = H_RES * V_RES;
   localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(FRAME - 1);
   localparam logic [ADDR_W:0]   FRAME_LIM = (ADDR_W + 1)'(FRAME);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARM     = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_HOLD    = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              seen_low_q, seen_low_d;
   logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic              rd_vld_p1_q, rd_vld_p1_d;
   logic              rd_valid_q;
   logic              frame_err_q, frame_err_d;
   logic              rd_in_range;

   // Reads beyond the frame never touch the RAM (ADDR_W may cover more than FRAME).
   assign rd_in_range = ({1'b0, bus.rd_addr_i} < FRAME_LIM);

   // Next-state: capture/hold schedule and the single RAM address mux.
   always_comb begin
      state_d     = state_q;
      seen_low_d  = seen_low_q;
      wr_cnt_d    = wr_cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      rd_vld_p1_d = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               state_d    = S_ARM;
               seen_low_d = 1'b0;
            end
         end
         S_ARM: begin
            // Only a low-then-high vsync edge proves we are at a frame start.
            if (seen_low_q && bus.vsync_i) begin
               state_d  = S_CAPTURE;
               wr_cnt_d = '0;
            end else if (!bus.vsync_i) begin
               seen_low_d = 1'b1;
            end
         end
         S_CAPTURE: begin
            // The final pixel wins over a simultaneous vsync fall.
            if (bus.pix_valid_i && (wr_cnt_q == LAST_PIX)) begin
               mem_we_d   = 1'b1;
               mem_addr_d = wr_cnt_q;
               state_d    = S_HOLD;
            end else if (!bus.vsync_i) begin
               // Short frame: the blanking already seen counts as the next boundary.
               frame_err_d = 1'b1;
               state_d     = S_ARM;
               seen_low_d  = 1'b1;
            end else if (bus.pix_valid_i) begin
               mem_we_d   = 1'b1;
               mem_addr_d = wr_cnt_q;
               wr_cnt_d   = wr_cnt_q + ADDR_W'(1);
            end
         end
         S_HOLD: begin
            // Release has priority; a read in the release/start cycle is dropped.
            if (bus.release_i) begin
               state_d = S_IDLE;
            end else if (bus.start_i) begin
               state_d    = S_ARM;
               seen_low_d = 1'b0;
            end else if (bus.rd_req_i && rd_in_range) begin
               mem_addr_d  = bus.rd_addr_i;
               rd_vld_p1_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset clears everything including in-flight reads.
   always_ff @(posedge CLK25) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         seen_low_q  <= 1'b0;
         wr_cnt_q    <= '0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         rd_vld_p1_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         seen_low_q  <= seen_low_d;
         wr_cnt_q    <= wr_cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         rd_vld_p1_q <= rd_vld_p1_d;
         // RAM read latency: data is valid one cycle after the address is presented.
         rd_valid_q  <= rd_vld_p1_q;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.mem_addr_o    = mem_addr_q;
   assign bus.mem_we_o      = mem_we_q;
   assign bus.rd_valid_o    = rd_valid_q;
   assign bus.frame_ready_o = (state_q == S_HOLD);
   assign bus.busy_o        = (state_q == S_ARM) || (state_q == S_CAPTURE);
   assign bus.frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl on a reduced 16x8 frame: directed sequences,
// a table of read-port vectors, and random traffic against a reference model.
module tb_frame_capture_ctrl;

   localparam int H     = 16;
   localparam int V     = 8;
   localparam int AW    = 8;
   localparam int FRAME = H * V;

   logic clk = 1'b0;
   logic rst_n;

   always #20 clk = ~clk;

   frame_capture_ctrl_if #(.ADDR_W(AW)) bus ();

   frame_capture_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
      .CLK25   (clk),
      .RESET_N (rst_n),
      .bus     (bus.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: what the frame buffer is doing, in plain terms.
   typedef enum {M_IDLE, M_WAIT, M_CAP, M_HOLD} mode_e;
   mode_e mode       = M_IDLE;
   bit    blank_seen = 1'b0;
   int    pix        = 0;
   int    m_addr     = 0;
   bit    m_we       = 1'b0;
   bit    m_rv       = 1'b0;
   bit    m_err      = 1'b0;
   bit    m_acc      = 1'b0;

   // Monitor statistics
   int wr_seen  = 0;
   int first_wr = -1;
   int last_wr  = -1;
   int err_seen = 0;

   typedef struct {
      bit rq; int ra; bit rel; bit st; bit pv;
      bit chk_a; int ea; bit erv; bit efr; bit ebusy; bit ewe;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit st, input bit rel, input bit vs,
                             input bit pv, input bit rq, input int ra);
      bit acc_next = 1'b0;
      m_we  = 1'b0;
      m_err = 1'b0;
      m_rv  = m_acc;
      if (!r) begin
         mode = M_IDLE; blank_seen = 1'b0; pix = 0;
         m_addr = 0; m_acc = 1'b0; m_rv = 1'b0;
         return;
      end
      case (mode)
         M_IDLE: if (st) begin mode = M_WAIT; blank_seen = 1'b0; end
         M_WAIT: begin
            if (blank_seen && vs) begin mode = M_CAP; pix = 0; end
            else if (!vs) blank_seen = 1'b1;
         end
         M_CAP: begin
            if (pv && pix == FRAME - 1) begin
               m_we = 1'b1; m_addr = pix; mode = M_HOLD;
            end else if (!vs) begin
               m_err = 1'b1; mode = M_WAIT; blank_seen = 1'b1;
            end else if (pv) begin
               m_we = 1'b1; m_addr = pix; pix++;
            end
         end
         M_HOLD: begin
            if (rel) mode = M_IDLE;
            else if (st) begin mode = M_WAIT; blank_seen = 1'b0; end
            else if (rq && ra < FRAME) begin m_addr = ra; acc_next = 1'b1; end
         end
         default: mode = M_IDLE;
      endcase
      m_acc = acc_next;
   endtask

   task automatic step(input bit r, input bit st, input bit rel, input bit vs,
                       input bit pv, input bit rq, input int ra);
      rst_n           = r;
      bus.start_i     = st;
      bus.release_i   = rel;
      bus.vsync_i     = vs;
      bus.pix_valid_i = pv;
      bus.rd_req_i    = rq;
      bus.rd_addr_i   = AW'(ra);
      @(posedge clk);
      model_edge(r, st, rel, vs, pv, rq, ra);
      #1;
      chk("mem_we", bus.mem_we_o, m_we);
      chk("rd_valid", bus.rd_valid_o, m_rv);
      chk("frame_err", bus.frame_err_o, m_err);
      chk("frame_ready", bus.frame_ready_o, mode == M_HOLD);
      chk("busy", bus.busy_o, (mode == M_WAIT) || (mode == M_CAP));
      if (m_we || m_acc) chk("mem_addr", bus.mem_addr_o, m_addr);
      if (bus.mem_we_o === 1'b1) begin
         if (wr_seen == 0) first_wr = int'(bus.mem_addr_o);
         last_wr = int'(bus.mem_addr_o);
         wr_seen++;
      end
      if (bus.frame_err_o === 1'b1) err_seen++;
   endtask

   task automatic quiet(input int n, input bit vs);
      for (int i = 0; i < n; i++) step(1, 0, 0, vs, 0, 0, 0);
   endtask

   // Blanking, then the rising vsync that opens a frame, then n pixels.
   task automatic frame_pixels(input int n, input bit last_vs);
      quiet(3, 0);
      quiet(1, 1);
      for (int i = 0; i < n; i++) step(1, 0, 0, (i == n - 1) ? last_vs : 1'b1, 1, 0, 0);
   endtask

   vec_t tbl[8];

   initial begin
      int err0;
      tbl[0] = '{rq:1, ra:5,   rel:0, st:0, pv:0, chk_a:1, ea:5,   erv:0, efr:1, ebusy:0, ewe:0};
      tbl[1] = '{rq:1, ra:127, rel:0, st:0, pv:0, chk_a:1, ea:127, erv:1, efr:1, ebusy:0, ewe:0};
      tbl[2] = '{rq:1, ra:128, rel:0, st:0, pv:0, chk_a:0, ea:0,   erv:1, efr:1, ebusy:0, ewe:0};
      tbl[3] = '{rq:0, ra:0,   rel:0, st:0, pv:0, chk_a:0, ea:0,   erv:0, efr:1, ebusy:0, ewe:0};
      tbl[4] = '{rq:1, ra:10,  rel:0, st:0, pv:0, chk_a:1, ea:10,  erv:0, efr:1, ebusy:0, ewe:0};
      tbl[5] = '{rq:1, ra:20,  rel:1, st:0, pv:0, chk_a:0, ea:0,   erv:1, efr:0, ebusy:0, ewe:0};
      tbl[6] = '{rq:1, ra:30,  rel:0, st:0, pv:1, chk_a:0, ea:0,   erv:0, efr:0, ebusy:0, ewe:0};
      tbl[7] = '{rq:0, ra:0,   rel:0, st:1, pv:0, chk_a:0, ea:0,   erv:0, efr:0, ebusy:1, ewe:0};

      // Reset values
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0);
      chk("rst_mem_we", bus.mem_we_o, 0);
      chk("rst_mem_addr", bus.mem_addr_o, 0);
      chk("rst_rd_valid", bus.rd_valid_o, 0);
      chk("rst_frame_ready", bus.frame_ready_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_frame_err", bus.frame_err_o, 0);

      // Full frame capture
      step(1, 1, 0, 1, 0, 0, 0);
      quiet(4, 1);
      wr_seen = 0;
      frame_pixels(FRAME, 1);
      chk("full_frame_ready", bus.frame_ready_o, 1);
      chk("full_busy", bus.busy_o, 0);
      quiet(1, 1);
      chk("full_writes", wr_seen, FRAME);
      chk("full_first_addr", first_wr, 0);
      chk("full_last_addr", last_wr, FRAME - 1);

      // Read port vectors from HOLD, ending with release then a fresh start
      foreach (tbl[i]) begin
         step(1, tbl[i].st, tbl[i].rel, 1, tbl[i].pv, tbl[i].rq, tbl[i].ra);
         chk($sformatf("tbl%0d_rd_valid", i), bus.rd_valid_o, tbl[i].erv);
         chk($sformatf("tbl%0d_frame_ready", i), bus.frame_ready_o, tbl[i].efr);
         chk($sformatf("tbl%0d_busy", i), bus.busy_o, tbl[i].ebusy);
         chk($sformatf("tbl%0d_mem_we", i), bus.mem_we_o, tbl[i].ewe);
         if (tbl[i].chk_a) chk($sformatf("tbl%0d_mem_addr", i), bus.mem_addr_o, tbl[i].ea);
      end

      // Armed mid-frame: pixels before a frame boundary are not written
      wr_seen = 0;
      for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 1, 0, 0);
      chk("midframe_no_writes", wr_seen, 0);

      // Short frame after 50 pixels
      err0 = err_seen;
      frame_pixels(50, 1);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("short_err_pulses", err_seen - err0, 1);
      chk("short_writes", wr_seen, 50);
      chk("short_back_to_arm", bus.busy_o, 1);

      // Next frame completes; vsync falls on the final pixel
      wr_seen = 0;
      quiet(2, 0);
      quiet(1, 1);
      for (int i = 0; i < FRAME; i++) step(1, 0, 0, (i == FRAME - 1) ? 1'b0 : 1'b1, 1, 0, 0);
      chk("retry_frame_ready", bus.frame_ready_o, 1);
      quiet(1, 0);
      chk("retry_no_extra_err", err_seen - err0, 1);
      chk("retry_writes", wr_seen, FRAME);
      chk("retry_first_addr", first_wr, 0);

      // Reset in the middle of a capture
      step(1, 0, 1, 1, 0, 0, 0);
      step(1, 1, 0, 1, 0, 0, 0);
      frame_pixels(64, 1);
      step(0, 0, 0, 1, 1, 1, 3);
      chk("abort_mem_we", bus.mem_we_o, 0);
      chk("abort_mem_addr", bus.mem_addr_o, 0);
      chk("abort_busy", bus.busy_o, 0);
      chk("abort_frame_ready", bus.frame_ready_o, 0);
      chk("abort_rd_valid", bus.rd_valid_o, 0);
      quiet(1, 1);
      chk("abort_no_write_after", bus.mem_we_o, 0);
      wr_seen = 0;
      step(1, 1, 0, 1, 0, 0, 0);
      frame_pixels(FRAME, 1);
      quiet(1, 1);
      chk("after_abort_writes", wr_seen, FRAME);
      chk("after_abort_first_addr", first_wr, 0);

      // Random traffic against the model
      begin
         int sent = 0, blank = 0, limit = FRAME;
         for (int i = 0; i < 6000; i++) begin
            bit vs, pv;
            if (blank > 0) begin
               vs = 1'b0; pv = 1'b0; blank--;
               if (blank == 0) begin
                  sent  = 0;
                  limit = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, FRAME - 1)) : FRAME;
               end
            end else begin
               vs = 1'b1;
               pv = ($urandom_range(0, 3) != 0) && (sent < limit);
               if (pv) sent++;
               else if (sent >= limit) blank = int'($urandom_range(1, 4));
            end
            step($urandom_range(0, 999) != 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 29) == 0, vs, pv, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 255)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Sequences the single-port 320x240 frame RAM between the camera capture path and the digit-recognition reader. On a `start` request it waits for the next complete camera frame and streams pixel write addresses into the RAM. It then freezes the buffer and lets the classifier read arbitrary addresses until the classifier releases it. This block replaces free-running address generation with an explicit capture/hold schedule, so a frame is never overwritten while it is being classified.

## Interface
- `H_RES`, default 320: pixels per line.
- `V_RES`, default 240: lines per frame.
- `ADDR_W`, default 17: frame RAM address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES.
- `CLK25`  in  1: 25 MHz pixel/system clock. One clock domain only.
- `RESET_N`  in  1: reset, synchronous and active-low.
- `start`  in  1: single-cycle request to capture the next full frame.
- `release`  in  1: single-cycle pulse; the reader is finished with the held frame.
- `vsync`  in  1: camera vsync, already synchronised to `CLK25`. Low marks vertical blanking / frame boundary.
- `pix_valid`  in  1: one cycle per camera pixel, in raster order.
- `rd_req`  in  1: reader access request, one address per cycle.
- `rd_addr`  in  ADDR_W: reader pixel address.
- `mem_addr`  out  ADDR_W: frame RAM address (registered).
- `mem_we`  out  1: frame RAM write enable (registered).
- `rd_valid`  out  1: RAM read data on the reader bus is valid this cycle.
- `frame_ready`  out  1: level; a complete frame is held and readable.
- `busy`  out  1: level; capture is armed or in progress.
- `frame_err`  out  1: single-cycle pulse on a short frame.

## Operation
- `FRAME = H_RES*V_RES` = 76800 by default. The pixel counter `wr_cnt` is ADDR_W bits and its terminal value is FRAME-1.
- State IDLE:
  - `start` → ARM. All other inputs are ignored.
- State ARM:
  - `seen_low` is cleared on entry and set while `vsync`=0.
  - When `seen_low`=1 and `vsync`=1 → CAPTURE, with `wr_cnt`=0.
  - `pix_valid` is ignored.
  - This rule guarantees capture begins at a frame start, never mid-frame.
- State CAPTURE:
  - On each `pix_valid`: next cycle `mem_we`=1 and `mem_addr`=`wr_cnt`; then `wr_cnt` increments.
  - When the pixel with `wr_cnt`=FRAME-1 is accepted → HOLD.
  - If `vsync`=0 while `wr_cnt` < FRAME (short frame): pulse `frame_err`, return to ARM with `seen_low`=1, and restart the capture on the next frame.
  - If `vsync` falls in the same cycle as the final pixel, the frame completes; this is not an error.
- State HOLD:
  - `frame_ready`=1 and `mem_we`=0.
  - On `rd_req` with `rd_addr` < FRAME: `mem_addr`=`rd_addr` is registered next cycle, and `rd_valid` is asserted the cycle after that (RAM has 1-cycle read latency).
  - On `rd_req` with `rd_addr` ≥ FRAME: no RAM access and no `rd_valid`.
  - `release` → IDLE. If `rd_req` arrives in the same cycle as `release`, the request is dropped. Reads already in flight still produce `rd_valid` on schedule.
  - `start` → ARM directly; it implies a release.
- `start` in ARM, CAPTURE or HOLD-with-`release` is ignored, beyond the transitions above.
- `release` outside HOLD is ignored.
- `rd_req` outside HOLD is ignored: no RAM access and no `rd_valid`.
- `busy` = (state is ARM or CAPTURE).
- `mem_we` is never 1 outside CAPTURE. The reader and the camera never drive the RAM in the same cycle.

## Timing
- Reset values:
  - state = IDLE
  - `wr_cnt` = 0, `seen_low` = 0
  - `mem_addr` = 0, `mem_we` = 0
  - `rd_valid` = 0, `frame_ready` = 0, `busy` = 0, `frame_err` = 0
  - The read-pipeline valid bits are cleared.
- `RESET_N` low mid-capture or mid-read aborts immediately at the next edge; there is no pending write or `rd_valid` afterward.
- Write latency: `pix_valid` at cycle n → `mem_we`/`mem_addr` at n+1.
- Read latency: `rd_req` at cycle n → `mem_addr` at n+1, `rd_valid` at n+2. Throughput is one read per cycle.
- `frame_ready` rises the cycle after the final pixel is accepted. It falls the cycle after `release` or `start`.
- The state transition on the final pixel and the `mem_we` for that pixel occur in the same cycle (n+1).

## Test plan
- Reset, `start`, `vsync` 1→0→1, then 76800 `pix_valid` pulses:
  - `mem_addr` steps 0..76799 with `mem_we`.
  - `frame_ready`=1 one cycle after the last pulse.
  - `busy`=0 once HOLD is reached.
- `start` while `vsync`=1 mid-frame, with pixels arriving:
  - No `mem_we` until `vsync` has gone low then high.
  - The first write is at `mem_addr`=0.
- `vsync` drops after 1000 pixels:
  - `frame_err` pulses once and the block returns to ARM.
  - The next full frame completes with writes starting at 0.
- In HOLD, `rd_req` for addresses 5, 76799, 76800 on consecutive cycles:
  - `mem_addr` = 5, then 76799.
  - `rd_valid` high for exactly 2 cycles, starting 2 cycles after the first request.
  - `mem_we` stays 0.
- `release` and `rd_req` in the same cycle:
  - The request is dropped and the block goes to IDLE.
  - A subsequent `rd_req` or `pix_valid` produces no RAM activity.
- `RESET_N`=0 at pixel 40000:
  - All outputs reach reset values next edge.
  - A new `start` captures a full frame from address 0.
